// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared encodings for the execute-stage ALU of the multicycle RISC-V core.
// The alu_op values must match what the ALU control unit emits.
// Contents:
//   - ALU_* operation codes and the ALU_B* branch-compare aliases
//   - alu_state_e : FSM state encoding of iterative_alu (IDLE / SHIFT)
//   - is_shift_op : true for the two shift codes (non-branch interpretation)
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_SRL = 4'b1011;

  // With is_branch=1 the same codes select a compare.
  localparam logic [3:0] ALU_BEQ = ALU_ADD;
  localparam logic [3:0] ALU_BNE = ALU_SLL;
  localparam logic [3:0] ALU_BLT = ALU_XOR;
  localparam logic [3:0] ALU_BGE = ALU_SRL;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// ---------------------------------------------------------------------------
// serial_shifter
// One-bit-per-cycle logical shifter used by iterative_alu.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   load        : capture operand / shamt / dir; counter := shamt
//   dir         : 0 = shift left, 1 = shift right (zero fill)
//   operand     : value to shift
//   shamt       : number of single-bit steps
//   result      : value after the step taken on the coming edge
//   last_step   : the coming edge performs the final step (counter == 1)
// The caller registers result when last_step is high, so the final value is
// available in the same edge the counter reaches zero.
// ---------------------------------------------------------------------------
module serial_shifter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               dir,
  input  logic [XLEN-1:0]    operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [XLEN-1:0]    result,
  output logic               last_step
);

  logic [XLEN-1:0]    data_p0;
  logic [SHAMT_W-1:0] cnt_p0;
  logic               dir_p0;
  logic [XLEN-1:0]    step_val;

  assign step_val  = dir_p0 ? (data_p0 >> 1) : (data_p0 << 1);
  assign result    = step_val;
  assign last_step = (cnt_p0 == SHAMT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_p0 <= '0;
      cnt_p0  <= '0;
      dir_p0  <= 1'b0;
    end else if (load) begin
      data_p0 <= operand;
      cnt_p0  <= shamt;
      dir_p0  <= dir;
    end else if (cnt_p0 != '0) begin
      data_p0 <= step_val;
      cnt_p0  <= cnt_p0 - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/iterative_alu.sv
// ---------------------------------------------------------------------------
// iterative_alu
// Registered execute-stage ALU. Add/sub/logic/branch compares complete in one
// cycle; shifts use a serial one-bit-per-cycle shifter behind a start/done
// handshake.
// Build option: define ITERATIVE_ALU_BARREL_SHIFT_EN to replace the serial
// shifter with a combinational barrel shift (no SHIFT state, busy tied 0).
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   start                : request, accepted only while busy=0
//   alu_op, is_branch    : operation select (captured on accept)
//   alu_in_1, alu_in_2   : operands A / B; B[SHAMT_W-1:0] is the shift amount
//   busy                 : serial shift in progress
//   done                 : one-cycle pulse, result/bcond valid from here on
//   alu_result, alu_bcond: registered outputs, held until the next done
// ---------------------------------------------------------------------------
module iterative_alu
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      alu_op,
  input  logic            is_branch,
  input  logic [XLEN-1:0] alu_in_1,
  input  logic [XLEN-1:0] alu_in_2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_bcond
);

  // Single-cycle evaluation: {bcond, result}. Shifts are barrel-shifted here;
  // the serial build only uses this path for shamt=0, where it returns A.
  function automatic logic [XLEN:0] alu_exec(
    input logic [3:0]      op,
    input logic            br,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [XLEN-1:0]        r;
    logic                   bc;
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [SHAMT_W-1:0]     sh;
    sa = a;
    sb = b;
    sh = b[SHAMT_W-1:0];
    r  = '0;
    bc = 1'b0;
    if (br) begin
      r = a - b;
      case (op)
        ALU_BEQ: bc = (a == b);
        ALU_BNE: bc = (a != b);
        ALU_BLT: bc = (sa < sb);
        ALU_BGE: bc = (sa >= sb);
        default: bc = 1'b0;
      endcase
    end else begin
      case (op)
        ALU_ADD: r = a + b;
        ALU_SUB: r = a - b;
        ALU_AND: r = a & b;
        ALU_OR:  r = a | b;
        ALU_XOR: r = a ^ b;
        ALU_SLL: r = a << sh;
        ALU_SRL: r = a >> sh;
        default: r = '0;
      endcase
    end
    return {bc, r};
  endfunction

  logic [XLEN-1:0] result_p1;
  logic            bcond_p1;
  logic            vld_p1;
  logic [XLEN:0]   exec_p0;

  assign exec_p0    = alu_exec(alu_op, is_branch, alu_in_1, alu_in_2);
  assign done       = vld_p1;
  assign alu_result = result_p1;
  assign alu_bcond  = bcond_p1;

`ifdef ITERATIVE_ALU_BARREL_SHIFT_EN

  assign busy = 1'b0;

  // Stage p0 -> p1: every accepted request completes on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      bcond_p1  <= 1'b0;
    end else begin
      vld_p1 <= start;
      if (start) begin
        result_p1 <= exec_p0[XLEN-1:0];
        bcond_p1  <= exec_p0[XLEN];
      end
    end
  end

`else

  alu_state_e         state_p1;
  alu_state_e         state_d;
  logic               accept;
  logic               go_shift;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    sh_result;
  logic               sh_last;
  logic               vld_d;
  logic [XLEN-1:0]    result_d;
  logic               bcond_d;

  assign shamt    = alu_in_2[SHAMT_W-1:0];
  assign accept   = start && (state_p1 == ST_IDLE);
  assign go_shift = accept && !is_branch && is_shift_op(alu_op) && (shamt != '0);
  assign busy     = (state_p1 == ST_SHIFT);

  serial_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_serial_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (go_shift),
    .dir       (alu_op == ALU_SRL),
    .operand   (alu_in_1),
    .shamt     (shamt),
    .result    (sh_result),
    .last_step (sh_last)
  );

  always_comb begin
    state_d  = state_p1;
    vld_d    = 1'b0;
    result_d = result_p1;
    bcond_d  = bcond_p1;
    case (state_p1)
      ST_IDLE: begin
        if (go_shift) begin
          state_d = ST_SHIFT;
        end else if (accept) begin
          vld_d    = 1'b1;
          result_d = exec_p0[XLEN-1:0];
          bcond_d  = exec_p0[XLEN];
        end
      end
      ST_SHIFT: begin
        // Capture the shifter's final step on the same edge it happens.
        if (sh_last) begin
          state_d  = ST_IDLE;
          vld_d    = 1'b1;
          result_d = sh_result;
          bcond_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p0 -> p1: outputs update only when an op completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1  <= ST_IDLE;
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      bcond_p1  <= 1'b0;
    end else begin
      state_p1  <= state_d;
      vld_p1    <= vld_d;
      result_p1 <= result_d;
      bcond_p1  <= bcond_d;
    end
  end

`endif

endmodule

// File: tb/tb_iterative_alu.sv
module tb_iterative_alu;

`ifdef ITERATIVE_ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  alu_op;
  logic        is_branch;
  logic [31:0] alu_in_1;
  logic [31:0] alu_in_2;
  logic        busy;
  logic        done;
  logic [31:0] alu_result;
  logic        alu_bcond;

  int n_cmp  = 0;
  int n_fail = 0;

  iterative_alu #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alu_op     (alu_op),
    .is_branch  (is_branch),
    .alu_in_1   (alu_in_1),
    .alu_in_2   (alu_in_2),
    .busy       (busy),
    .done       (done),
    .alu_result (alu_result),
    .alu_bcond  (alu_bcond)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        br;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        bc;
    int          lat;   // cycles from start to done in the serial build
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model from the operation rules, shifts as multiply/divide by 2^n.
  task automatic model(input logic [3:0] op, input logic br, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output logic bc,
                       output int lat);
    int  sh;
    longint sa, sb;
    sh  = int'(b % 32);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 32'd0;
    bc  = 1'b0;
    lat = 1;
    if (br) begin
      res = 32'((64'(a) + 64'h1_0000_0000) - 64'(b));
      case (op)
        4'b0000: bc = (a == b);
        4'b1010: bc = (a != b);
        4'b1000: bc = (sa < sb);
        4'b1011: bc = (sa >= sb);
        default: bc = 1'b0;
      endcase
    end else begin
      case (op)
        4'b0000: res = 32'(64'(a) + 64'(b));
        4'b0001: res = 32'((64'(a) + 64'h1_0000_0000) - 64'(b));
        4'b0100: res = a & b;
        4'b0101: res = a | b;
        4'b1000: res = a ^ b;
        4'b1010: res = 32'(64'(a) * (64'd1 << sh));
        4'b1011: res = 32'(64'(a) / (64'd1 << sh));
        default: res = 32'd0;
      endcase
      if ((op == 4'b1010 || op == 4'b1011) && sh != 0 && !BARREL) lat = sh + 1;
    end
  endtask

  // Issue one op with start held for a single cycle; returns the outputs seen
  // in the done cycle, the latency and the number of busy cycles before done.
  task automatic issue(input logic [3:0] op, input logic br, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output logic bc,
                       output int lat, output int busy_cnt, output logic busy_at_done);
    @(negedge clk);
    alu_op = op; is_branch = br; alu_in_1 = a; alu_in_2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    alu_in_1 = $urandom; alu_in_2 = $urandom; alu_op = 4'($urandom);
    lat = 1; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: done not seen within %0d cycles", lat);
    end
    res = alu_result; bc = alu_bcond; busy_at_done = busy;
  endtask

  task automatic run_check(input string name, input logic [3:0] op, input logic br,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic exp_bc, input int exp_lat);
    logic [31:0] r; logic bc; int lat, bcnt; logic bad;
    issue(op, br, a, b, r, bc, lat, bcnt, bad);
    check({name, " result"}, 64'(r), 64'(exp_res));
    check({name, " bcond"},  64'(bc), 64'(exp_bc));
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " busy cycles"}, 64'(bcnt), 64'(exp_lat - 1));
    check({name, " busy at done"}, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [31:0] mr; logic mb; int ml;
    logic [3:0] codes[9] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h8, 4'hA, 4'hB, 4'h3, 4'hF};

    reset = 1'b1; start = 1'b0; alu_op = 4'h0; is_branch = 1'b0;
    alu_in_1 = 32'd0; alu_in_2 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy",   64'(busy), 64'd0);
    check("reset done",   64'(done), 64'd0);
    check("reset result", 64'(alu_result), 64'd0);
    check("reset bcond",  64'(alu_bcond), 64'd0);
    @(negedge clk); reset = 1'b0;

    // op, br, a, b, result, bcond, serial latency
    vecs.push_back('{4'h0, 1'b0, 32'd3,          32'd4,          32'd7,          1'b0, 1});
    vecs.push_back('{4'h1, 1'b0, 32'd5,          32'd7,          32'hFFFF_FFFE, 1'b0, 1});
    vecs.push_back('{4'h4, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1});
    vecs.push_back('{4'h5, 1'b0, 32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF, 1'b0, 1});
    vecs.push_back('{4'h8, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1});
    vecs.push_back('{4'h3, 1'b0, 32'd1,          32'd2,          32'd0,          1'b0, 1});
    vecs.push_back('{4'h0, 1'b0, 32'hFFFF_FFFF, 32'd1,          32'd0,          1'b0, 1});
    vecs.push_back('{4'h8, 1'b1, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFE, 1'b1, 1});
    vecs.push_back('{4'hB, 1'b1, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFE, 1'b0, 1});
    vecs.push_back('{4'h8, 1'b1, 32'd1,          32'hFFFF_FFFF, 32'd2,          1'b0, 1});
    vecs.push_back('{4'h0, 1'b1, 32'd5,          32'd5,          32'd0,          1'b1, 1});
    vecs.push_back('{4'hA, 1'b1, 32'd5,          32'd5,          32'd0,          1'b0, 1});
    vecs.push_back('{4'hA, 1'b1, 32'd5,          32'd6,          32'hFFFF_FFFF, 1'b1, 1});
    vecs.push_back('{4'h1, 1'b1, 32'd3,          32'd3,          32'd0,          1'b0, 1});
    vecs.push_back('{4'hB, 1'b0, 32'h8000_0000, 32'd0,          32'h8000_0000, 1'b0, 1});
    vecs.push_back('{4'hB, 1'b0, 32'h8000_0000, 32'd4,          32'h0800_0000, 1'b0, 5});
    vecs.push_back('{4'hA, 1'b0, 32'd1,          32'd31,         32'h8000_0000, 1'b0, 32});
    vecs.push_back('{4'hA, 1'b0, 32'd3,          32'h20,         32'd3,          1'b0, 1});
    vecs.push_back('{4'hA, 1'b0, 32'h8000_0001, 32'd1,          32'd2,          1'b0, 2});

    for (int i = 0; i < vecs.size(); i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].br, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].bc, BARREL ? 1 : vecs[i].lat);
    end

    // SLL shamt=31 with start held high (ADD requests) while busy.
    begin
      int lat; logic [31:0] exp_r;
      exp_r = BARREL ? 32'h8000_0000 : 32'h8000_0000;
      @(negedge clk);
      alu_op = 4'hA; is_branch = 1'b0; alu_in_1 = 32'd1; alu_in_2 = 32'd31; start = 1'b1;
      @(posedge clk); #1;
      alu_op = 4'h0; alu_in_1 = 32'd100; alu_in_2 = 32'd200;
      lat = 1;
      start = !BARREL;
      while (!done && lat < 100) begin
        @(posedge clk); #1;
        lat++;
        start = (lat <= 30) && !BARREL;
      end
      start = 1'b0;
      check("busy-start result", 64'(alu_result), 64'(exp_r));
      check("busy-start latency", 64'(lat), BARREL ? 64'd1 : 64'd32);
      @(posedge clk); #1;
      check("busy-start single done", 64'(done), 64'd0);
      check("busy-start held", 64'(alu_result), 64'(exp_r));
    end

    // Back-to-back XOR, OR, AND with start held.
    @(negedge clk);
    is_branch = 1'b0; alu_in_1 = 32'hAAAA_5555; alu_in_2 = 32'h0F0F_F0F0; start = 1'b1;
    alu_op = 4'h8;
    @(negedge clk); alu_op = 4'h5;
    check("b2b xor done", 64'(done), 64'd1);
    check("b2b xor result", 64'(alu_result), 64'hA5A5_A5A5);
    @(negedge clk); alu_op = 4'h4;
    check("b2b or done", 64'(done), 64'd1);
    check("b2b or result", 64'(alu_result), 64'hAFAF_F5F5);
    @(negedge clk); start = 1'b0;
    check("b2b and done", 64'(done), 64'd1);
    check("b2b and result", 64'(alu_result), 64'h0A0A_5050);
    @(negedge clk);
    check("b2b idle done", 64'(done), 64'd0);

    // Reset mid-shift: SLL shamt=20, reset in cycle 5.
    begin
      int seen_done;
      @(negedge clk);
      alu_op = 4'hA; is_branch = 1'b0; alu_in_1 = 32'h0000_0123; alu_in_2 = 32'd20; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      check("mid-shift busy", 64'(busy), BARREL ? 64'd0 : 64'd1);
      #2 reset = 1'b1;
      #1;
      check("async reset busy",   64'(busy), 64'd0);
      check("async reset done",   64'(done), 64'd0);
      check("async reset result", 64'(alu_result), 64'd0);
      check("async reset bcond",  64'(alu_bcond), 64'd0);
      @(negedge clk); reset = 1'b0;
      seen_done = 0;
      repeat (25) begin
        @(posedge clk); #1;
        if (done || busy) seen_done++;
      end
      check("aborted op silent", 64'(seen_done), 64'd0);
      check("post-reset result", 64'(alu_result), 64'd0);
      run_check("post-reset add", 4'h0, 1'b0, 32'd3, 32'd4, 32'd7, 1'b0, 1);
    end

    // Randomized ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op; logic br; logic [31:0] a, b;
      op = codes[$urandom_range(0, 8)];
      br = 1'($urandom_range(0, 3) == 0);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      model(op, br, a, b, mr, mb, ml);
      run_check($sformatf("rand%0d op%0h br%0d", i, op, br), op, br, a, b, mr, mb, ml);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
